dallanma_ongorucu: RTL and testbench

- Gshare conditional-branch predictor with a direct-mapped branch target buffer (BTB), located in the fetch stage.
- Predicts taken/not-taken and the target address for the current fetch PC in the same cycle, with no added latency.
- Consumes the branch unit's resolution outputs from execute: update valid, actual taken, misprediction flag.
- Trains its 2-bit counters and BTB from those outputs, and repairs the speculative global history on a misprediction.

---
 rtl/dallanma_pkg.sv | 27 ++
 rtl/dallanma_ongorucu_doygun_sayac.sv | 24 ++
 rtl/dallanma_ongorucu.sv | 128 ++++++++++++
 tb/tb_dallanma_ongorucu.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/dallanma_pkg.sv
// Shared definitions for the gshare branch predictor: counter encodings,
// default sizing and the branch-type codes used by upstream decode.
package dallanma_pkg;

    // 2-bit saturating counter encodings
    localparam logic [1:0] GUCLU_ATLAMAZ = 2'b00;
    localparam logic [1:0] ZAYIF_ATLAMAZ = 2'b01;
    localparam logic [1:0] ZAYIF_ATLAR   = 2'b10;
    localparam logic [1:0] GUCLU_ATLAR   = 2'b11;

    // Default predictor sizing
    localparam int unsigned VARSAYILAN_BHT_GIRDI = 64;
    localparam int unsigned VARSAYILAN_GGK_BIT   = 6;
    localparam int unsigned VARSAYILAN_BTB_GIRDI = 16;
    localparam int unsigned VARSAYILAN_PS_BIT    = 32;

    // Conditional branch types as encoded by decode
    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b010,
        BGE  = 3'b011,
        BLTU = 3'b100,
        BGEU = 3'b101
    } dallanma_tipi_t;

endpackage

// File: rtl/dallanma_ongorucu_doygun_sayac.sv
// Next-state function of a 2-bit saturating branch counter.
module doygun_sayac
    import dallanma_pkg::*;
(
    input  logic [1:0] mevcut,
    input  logic       atladi,
    output logic [1:0] sonraki
);

    // Step toward taken/not-taken, holding at either end of the range
    always_comb begin
        sonraki = mevcut;
        if (atladi) begin
            if (mevcut != GUCLU_ATLAR) begin
                sonraki = mevcut + 2'b01;
            end
        end else begin
            if (mevcut != GUCLU_ATLAMAZ) begin
                sonraki = mevcut - 2'b01;
            end
        end
    end

endmodule

// File: rtl/dallanma_ongorucu.sv
// Fetch-stage gshare predictor with a direct-mapped BTB. Lookup is purely
// combinational; training and history repair come from the execute stage.
module dallanma_ongorucu
    import dallanma_pkg::*;
#(
    parameter int unsigned BHT_GIRDI = VARSAYILAN_BHT_GIRDI,
    parameter int unsigned GGK_BIT   = VARSAYILAN_GGK_BIT,
    parameter int unsigned BTB_GIRDI = VARSAYILAN_BTB_GIRDI,
    parameter int unsigned PS_BIT    = VARSAYILAN_PS_BIT
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [PS_BIT-1:0]  ps_i,
    input  logic               ps_gecerli_i,
    output logic               ongoru_atlar_o,
    output logic [PS_BIT-1:0]  ongoru_hedef_o,
    output logic [GGK_BIT-1:0] ongoru_ggk_o,
    input  logic               guncelle_gecerli_i,
    input  logic               guncelle_atladi_i,
    input  logic [PS_BIT-1:0]  guncelle_ps_i,
    input  logic [PS_BIT-1:0]  guncelle_hedef_i,
    input  logic [GGK_BIT-1:0] guncelle_ggk_i,
    input  logic               dallanma_hata_i
);

    localparam int unsigned IDX_BIT = $clog2(BHT_GIRDI);
    localparam int unsigned BTB_IDX = $clog2(BTB_GIRDI);
    localparam int unsigned TAG_BIT = PS_BIT - BTB_IDX - 2;

    // Predictor state
    logic [1:0]         sayac      [BHT_GIRDI];
    logic [BTB_GIRDI-1:0] btb_gecerli;
    logic [TAG_BIT-1:0] btb_etiket [BTB_GIRDI];
    logic [PS_BIT-1:0]  btb_hedef  [BTB_GIRDI];
    logic [GGK_BIT-1:0] ggk;

    // Lookup side
    logic [IDX_BIT-1:0] i_idx;
    logic [BTB_IDX-1:0] b_idx;
    logic [TAG_BIT-1:0] etiket;
    logic               isabet;
    logic               atlar;

    // Update side
    logic [IDX_BIT-1:0] u_idx;
    logic [BTB_IDX-1:0] ub_idx;
    logic [TAG_BIT-1:0] u_etiket;
    logic [1:0]         sayac_sonraki;
    logic [GGK_BIT-1:0] ggk_sonraki;

    // Instruction-alignment bits never take part in indexing
    logic unused_hizalama;
    assign unused_hizalama = ^{ps_i[1:0], guncelle_ps_i[1:0]};

    // Combinational lookup: gshare index, BTB index and tag compare
    always_comb begin
        i_idx  = ps_i[IDX_BIT+1:2] ^ ggk;
        b_idx  = ps_i[BTB_IDX+1:2];
        etiket = ps_i[PS_BIT-1:BTB_IDX+2];
        isabet = btb_gecerli[b_idx] && (btb_etiket[b_idx] == etiket);
        atlar  = isabet && sayac[i_idx][1];
    end

    assign ongoru_atlar_o = atlar;
    assign ongoru_hedef_o = isabet ? btb_hedef[b_idx] : '0;
    assign ongoru_ggk_o   = ggk;

    // Update indices derived from the history snapshot the branch carried
    always_comb begin
        u_idx    = guncelle_ps_i[IDX_BIT+1:2] ^ guncelle_ggk_i;
        ub_idx   = guncelle_ps_i[BTB_IDX+1:2];
        u_etiket = guncelle_ps_i[PS_BIT-1:BTB_IDX+2];
    end

    doygun_sayac u_doygun_sayac (
        .mevcut  (sayac[u_idx]),
        .atladi  (guncelle_atladi_i),
        .sonraki (sayac_sonraki)
    );

    // Next history: misprediction repair outranks the speculative shift
    always_comb begin
        ggk_sonraki = ggk;
        if (guncelle_gecerli_i && dallanma_hata_i) begin
            ggk_sonraki = {guncelle_ggk_i[GGK_BIT-2:0], guncelle_atladi_i};
        end else if (ps_gecerli_i && isabet) begin
            ggk_sonraki = {ggk[GGK_BIT-2:0], atlar};
        end
    end

    // Global history register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ggk <= '0;
        end else begin
            ggk <= ggk_sonraki;
        end
    end

    // Counter table: reset to weakly not-taken, train on every resolution
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < BHT_GIRDI; i++) begin
                sayac[i] <= ZAYIF_ATLAMAZ;
            end
        end else if (guncelle_gecerli_i) begin
            sayac[u_idx] <= sayac_sonraki;
        end
    end

    // BTB valid bits: set only by taken resolutions
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            btb_gecerli <= '0;
        end else if (guncelle_gecerli_i && guncelle_atladi_i) begin
            btb_gecerli[ub_idx] <= 1'b1;
        end
    end

    // BTB tag/target payload; gated by reset so a reset cycle writes nothing
    always_ff @(posedge clk_i) begin
        if (rst_ni && guncelle_gecerli_i && guncelle_atladi_i) begin
            btb_etiket[ub_idx] <= u_etiket;
            btb_hedef[ub_idx]  <= guncelle_hedef_i;
        end
    end

endmodule

// File: tb/tb_dallanma_ongorucu.sv
// Directed bench for the gshare predictor with an expectation scoreboard.
module tb_dallanma_ongorucu;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] ps_i;
    logic        ps_gecerli_i;
    logic        ongoru_atlar_o;
    logic [31:0] ongoru_hedef_o;
    logic [5:0]  ongoru_ggk_o;
    logic        guncelle_gecerli_i;
    logic        guncelle_atladi_i;
    logic [31:0] guncelle_ps_i;
    logic [31:0] guncelle_hedef_i;
    logic [5:0]  guncelle_ggk_i;
    logic        dallanma_hata_i;

    typedef struct {
        string       etiket;
        logic        atlar;
        logic [31:0] hedef;
        logic [5:0]  ggk;
    } beklenen_t;

    beklenen_t kuyruk[$];
    int unsigned kontrol_sayisi = 0;
    int unsigned hata_sayisi    = 0;

    dallanma_ongorucu #(
        .BHT_GIRDI (64),
        .GGK_BIT   (6),
        .BTB_GIRDI (16),
        .PS_BIT    (32)
    ) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .ps_i               (ps_i),
        .ps_gecerli_i       (ps_gecerli_i),
        .ongoru_atlar_o     (ongoru_atlar_o),
        .ongoru_hedef_o     (ongoru_hedef_o),
        .ongoru_ggk_o       (ongoru_ggk_o),
        .guncelle_gecerli_i (guncelle_gecerli_i),
        .guncelle_atladi_i  (guncelle_atladi_i),
        .guncelle_ps_i      (guncelle_ps_i),
        .guncelle_hedef_i   (guncelle_hedef_i),
        .guncelle_ggk_i     (guncelle_ggk_i),
        .dallanma_hata_i    (dallanma_hata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic saat();
        @(posedge clk_i);
        #1;
    endtask

    task automatic guncelle(input logic gec, input logic atl, input logic hata,
                            input logic [31:0] ps, input logic [31:0] hedef,
                            input logic [5:0] ggk);
        guncelle_gecerli_i = gec;
        guncelle_atladi_i  = atl;
        dallanma_hata_i    = hata;
        guncelle_ps_i      = ps;
        guncelle_hedef_i   = hedef;
        guncelle_ggk_i     = ggk;
    endtask

    task automatic bekle(input string etiket, input logic atlar,
                         input logic [31:0] hedef, input logic [5:0] ggk);
        beklenen_t b;
        b.etiket = etiket;
        b.atlar  = atlar;
        b.hedef  = hedef;
        b.ggk    = ggk;
        kuyruk.push_back(b);
    endtask

    task automatic kontrol();
        beklenen_t b;
        #1;
        kontrol_sayisi++;
        assert (kuyruk.size() != 0) else begin
            hata_sayisi++;
            $error("FAIL scoreboard_empty observed 0 entries expected >=1");
        end
        if (kuyruk.size() != 0) begin
            b = kuyruk.pop_front();
            kontrol_sayisi++;
            assert (ongoru_atlar_o === b.atlar) else begin
                hata_sayisi++;
                $error("FAIL %s.atlar observed %0b expected %0b", b.etiket, ongoru_atlar_o, b.atlar);
            end
            kontrol_sayisi++;
            assert (ongoru_hedef_o === b.hedef) else begin
                hata_sayisi++;
                $error("FAIL %s.hedef observed %08h expected %08h", b.etiket, ongoru_hedef_o, b.hedef);
            end
            kontrol_sayisi++;
            assert (ongoru_ggk_o === b.ggk) else begin
                hata_sayisi++;
                $error("FAIL %s.ggk observed %06b expected %06b", b.etiket, ongoru_ggk_o, b.ggk);
            end
        end
    endtask

    logic ayri_beklenen [4] = '{1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        rst_ni       = 1'b0;
        ps_i         = 32'h100;
        ps_gecerli_i = 1'b0;
        guncelle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 6'h0);

        // Reset state
        saat();
        saat();
        bekle("reset", 1'b0, 32'h0, 6'h00);
        kontrol();
        rst_ni = 1'b1;

        // Two taken updates: miss before, hit with 10 then 11
        guncelle(1'b1, 1'b1, 1'b0, 32'h100, 32'h200, 6'h00);
        bekle("t2_before", 1'b0, 32'h0, 6'h00);
        kontrol();
        saat();
        bekle("t2_first", 1'b1, 32'h200, 6'h00);
        kontrol();
        saat();
        guncelle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 6'h00);
        bekle("t2_second", 1'b1, 32'h200, 6'h00);
        kontrol();

        // Four not-taken updates: 10, 01, 00, 00; BTB untouched
        for (int i = 0; i < 4; i++) begin
            guncelle(1'b1, 1'b0, 1'b0, 32'h100, 32'h3fc, 6'h00);
            saat();
            bekle($sformatf("t3_nt%0d", i), ayri_beklenen[i], 32'h200, 6'h00);
            kontrol();
        end
        // Floor held at 00: one taken step must give 01, not wrap
        guncelle(1'b1, 1'b1, 1'b0, 32'h100, 32'h200, 6'h00);
        saat();
        bekle("t3_floor", 1'b0, 32'h200, 6'h00);
        kontrol();
        saat();
        bekle("t3_up10", 1'b1, 32'h200, 6'h00);
        kontrol();
        saat();
        guncelle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 6'h00);
        bekle("t3_up11", 1'b1, 32'h200, 6'h00);
        kontrol();

        // Speculative shift on a taken hit
        ps_gecerli_i = 1'b1;
        saat();
        ps_gecerli_i = 1'b0;
        bekle("t4_shift", 1'b0, 32'h200, 6'b000001);
        kontrol();

        // Repair beats speculative shift in the same cycle
        ps_gecerli_i = 1'b1;
        guncelle(1'b1, 1'b0, 1'b1, 32'h300, 32'h0, 6'b101010);
        saat();
        ps_gecerli_i = 1'b0;
        guncelle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 6'h00);
        bekle("t5_repair", 1'b0, 32'h200, 6'b010100);
        kontrol();

        // Misprediction flag without a valid update is ignored
        guncelle(1'b0, 1'b1, 1'b1, 32'h100, 32'h0, 6'b111111);
        saat();
        guncelle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 6'h00);
        bekle("t5_ignore", 1'b0, 32'h200, 6'b010100);
        kontrol();

        // Same-index read and write: old values now, new next cycle
        guncelle(1'b1, 1'b1, 1'b0, 32'h100, 32'h280, 6'b010100);
        bekle("t6_old", 1'b0, 32'h200, 6'b010100);
        kontrol();
        saat();
        guncelle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 6'h00);
        bekle("t6_new", 1'b1, 32'h280, 6'b010100);
        kontrol();

        // Alias: same BTB index, different tag is a miss
        ps_i = 32'h140;
        bekle("t6_alias", 1'b0, 32'h0, 6'b010100);
        kontrol();

        // Not-taken updates of an absent PC still train its counter
        guncelle(1'b1, 1'b0, 1'b0, 32'h140, 32'h0, 6'b010100);
        saat();
        saat();
        guncelle(1'b1, 1'b1, 1'b0, 32'h140, 32'h340, 6'b010100);
        saat();
        guncelle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 6'h00);
        bekle("absent_train", 1'b0, 32'h340, 6'b010100);
        kontrol();
        ps_i = 32'h100;
        bekle("replaced", 1'b0, 32'h0, 6'b010100);
        kontrol();

        // Reset overrides a concurrent update
        ps_i = 32'h140;
        rst_ni = 1'b0;
        guncelle(1'b1, 1'b1, 1'b1, 32'h140, 32'h340, 6'b111111);
        saat();
        rst_ni = 1'b1;
        guncelle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 6'h00);
        bekle("reset_override", 1'b0, 32'h0, 6'h00);
        kontrol();

        kontrol_sayisi++;
        assert (kuyruk.size() == 0) else begin
            hata_sayisi++;
            $error("FAIL scoreboard_leftover observed %0d expected 0", kuyruk.size());
        end

        $display("CHECKS %0d ERRORS %0d", kontrol_sayisi, hata_sayisi);
        $finish;
    end

endmodule
